// File: rtl/fb_write_arbiter.sv
// Write-port arbiter for the HDMI pattern frame buffer: shares one buffer write port between
// two requesters and schedules the buffer-swap toggle inside vertical sync.
module fb_write_arbiter #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 24,
    parameter int unsigned BURST_MAX = 16
) (
    input  logic              clk_150,
    input  logic              reset_n,
    input  logic              vsync,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              swap_req,
    output logic              swap_busy,
    output logic              swap_done,
    output logic              web,
    output logic [ADDR_W-1:0] addr_in,
    output logic [DATA_W-1:0] dinb,
    output logic              toggle,
    output logic [15:0]       frame_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StOwn0,
        StOwn1,
        StSwapWait,
        StSwapFire
    } state_e;

    localparam logic [7:0] BurstLast = 8'(BURST_MAX - 1);

    state_e            state_q, state_d;
    logic [7:0]        burst_q, burst_d;
    logic              last_q, last_d;
    logic              pend_q, pend_d;
    logic              toggle_q, toggle_d;
    logic [15:0]       frame_q, frame_d;
    logic              vsync_q;
    logic              web_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    logic own_valid, oth_valid, vsync_rise, hs0, hs1;

    assign vsync_rise = vsync & ~vsync_q;
    assign hs0        = req0_valid && (state_q == StOwn0);
    assign hs1        = req1_valid && (state_q == StOwn1);
    assign own_valid  = (state_q == StOwn0) ? req0_valid : req1_valid;
    assign oth_valid  = (state_q == StOwn0) ? req1_valid : req0_valid;

    always_comb begin
        state_d  = state_q;
        burst_d  = burst_q;
        last_d   = last_q;
        pend_d   = pend_q;
        toggle_d = 1'b0;
        frame_d  = frame_q;
        unique case (state_q)
            StIdle, StOwn0, StOwn1: begin
                if (swap_req || pend_q) begin
                    state_d = StSwapWait;
                    pend_d  = 1'b1;
                end else if (state_q == StIdle) begin
                    // last_q == 1 means requester 1 was served last, so requester 0 wins a tie
                    if (req0_valid && (!req1_valid || last_q)) begin
                        state_d = StOwn0;
                        burst_d = '0;
                        last_d  = 1'b0;
                    end else if (req1_valid) begin
                        state_d = StOwn1;
                        burst_d = '0;
                        last_d  = 1'b1;
                    end
                end else if (own_valid && (!oth_valid || (burst_q < BurstLast))) begin
                    burst_d = (burst_q < BurstLast) ? burst_q + 8'd1 : burst_q;
                end else if (oth_valid) begin
                    state_d = (state_q == StOwn0) ? StOwn1 : StOwn0;
                    burst_d = '0;
                    last_d  = (state_q == StOwn0);
                end else if (own_valid) begin
                    burst_d = BurstLast;
                end else begin
                    state_d = StIdle;
                end
            end
            StSwapWait: begin
                if (vsync_rise) begin
                    state_d  = StSwapFire;
                    toggle_d = 1'b1;
                    pend_d   = 1'b0;
                    frame_d  = frame_q + 16'd1;
                end
            end
            StSwapFire: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_150) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            burst_q  <= '0;
            last_q   <= 1'b1;
            pend_q   <= 1'b0;
            toggle_q <= 1'b0;
            frame_q  <= '0;
            vsync_q  <= 1'b0;
            web_q    <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            burst_q  <= burst_d;
            last_q   <= last_d;
            pend_q   <= pend_d;
            toggle_q <= toggle_d;
            frame_q  <= frame_d;
            vsync_q  <= vsync;
            web_q    <= hs0 | hs1;
            if (hs0) begin
                addr_q <= req0_addr;
                data_q <= req0_data;
            end else if (hs1) begin
                addr_q <= req1_addr;
                data_q <= req1_data;
            end
        end
    end

    assign req0_ready = (state_q == StOwn0);
    assign req1_ready = (state_q == StOwn1);
    assign swap_busy  = pend_q;
    assign swap_done  = toggle_q;
    assign toggle     = toggle_q;
    assign frame_cnt  = frame_q;
    assign web        = web_q;
    assign addr_in    = addr_q;
    assign dinb       = data_q;

endmodule

// File: doc/fb_write_arbiter.md
# fb_write_arbiter

Write-port arbiter and buffer-swap scheduler for the HDMI pattern frame buffer. It shares the single buffer write port (`web`/`dinb`/`addr_in`) between two write requesters, requester 0 being the CPU bridge and requester 1 the fill engine. It also issues the buffer-swap `toggle` only inside vertical sync, so a swap never tears a displayed frame. It sits between the requesters and the HDMI top's video-input ports, clocked by the pixel clock.

## Interface
Parameters:
- `ADDR_W`, 16: buffer address width.
- `DATA_W`, 24: pixel data width.
- `BURST_MAX`, 16: maximum consecutive beats granted to one requester while the other is waiting. Legal range 1..255.

Ports:
- `clk_150`  in  1  pixel clock; the only clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `vsync`  in  1  active-high vertical sync from the HDMI timing generator.
- `req0_valid`, `req1_valid`  in  1  write request.
- `req0_addr`, `req1_addr`  in  ADDR_W  write address.
- `req0_data`, `req1_data`  in  DATA_W  write data.
- `req0_ready`, `req1_ready`  out  1  beat accepted when valid & ready.
- `swap_req`  in  1  single-cycle pulse requesting a buffer swap.
- `swap_busy`  out  1  a swap is pending; write acceptance is stalled.
- `swap_done`  out  1  single-cycle pulse, coincident with `toggle`.
- `web`  out  1  buffer write enable.
- `addr_in`  out  ADDR_W  buffer write address.
- `dinb`  out  DATA_W  buffer write data.
- `toggle`  out  1  single-cycle swap pulse to the frame buffer.
- `frame_cnt`  out  16  count of completed swaps; wraps from 0xFFFF to 0.

## Operation
- **States:** IDLE, OWN0, OWN1, SWAP_WAIT, SWAP_FIRE.
- **Ready outputs:** `reqN_ready` = (state == OWNN). They are combinational from state only and never depend on `reqN_valid`.
- **Grant decision:** evaluated every cycle while in IDLE, OWN0 or OWN1, after any swap check.
  - If `swap_pending`, go to SWAP_WAIT.
  - Else if the current owner is valid and either the other requester is not valid or `burst_cnt` < BURST_MAX - 1, stay and increment `burst_cnt`.
  - Else if the other requester is valid, switch owner and clear `burst_cnt` to 0.
  - Else if the current owner is valid, stay and keep `burst_cnt` saturated at BURST_MAX - 1.
  - Else go to IDLE.
- **IDLE with both requesters valid:** grant the requester not recorded in `last_served`. `last_served` resets to 1, so requester 0 wins first.
- **Entering OWN0/OWN1 from IDLE:** happens the cycle after the request is seen, with `burst_cnt` = 0. One cycle of grant latency applies only from IDLE.
- **Write path:** on a handshake (valid & ready) in cycle N, `web` = 1 with the captured address and data in cycle N+1. Otherwise `web` = 0 and `addr_in`/`dinb` hold their last value.
- **Swap request:** `swap_req` in IDLE, OWN0 or OWN1 sets `swap_pending` and `swap_busy`.
  - The next state is SWAP_WAIT. A handshake in the same cycle as `swap_req` still completes.
  - `swap_req` while `swap_busy` = 1 is ignored; requests are not queued.
- **SWAP_WAIT:** no ready is asserted. Wait for a vsync rising edge (`vsync` & ~`vsync_d`, with `vsync_d` registered) seen while in SWAP_WAIT. An edge seen in the entry cycle counts; an edge before entry does not. On the edge, go to SWAP_FIRE.
- **SWAP_FIRE:** lasts one cycle.
  - `toggle` = 1 and `swap_done` = 1 for that cycle.
  - `frame_cnt` increments.
  - `swap_pending` and `swap_busy` clear.
  - Next state is IDLE.

## Timing
- **Reset values:** all outputs 0, including `web`, `addr_in`, `dinb`, `toggle`, `swap_done`, `swap_busy`, `frame_cnt` and both readys. Internally, state = IDLE, `burst_cnt` = 0, `vsync_d` = 0, `last_served` = 1.
- **Reset mid-operation:** all of the above apply, and any pending swap is dropped with no `toggle`.
- **Latency:**
  - Handshake to `web`: 1 cycle.
  - `swap_req` to SWAP_WAIT: 1 cycle.
  - vsync edge sample to `toggle`: 1 cycle.
- **Ordering guarantee:** the last accepted write's `web` precedes `toggle` by at least 1 cycle.
- **Throughput:** 1 write per cycle sustained while an owner stays valid. No bubble on an owner switch between OWN0 and OWN1.
- **Boundaries:**
  - Inputs may change while ready = 0 with no effect.
  - `vsync` held high across SWAP_WAIT entry does not fire until it next rises.

## Test plan
- **Single writer:** after reset, `req0_valid` = 1 with `addr` = 0x0010, `data` = 0xABCDEF. Expect `req0_ready` 1 cycle later, then `web` = 1 with `addr_in` = 0x0010 and `dinb` = 0xABCDEF on the following cycle, with exactly one beat accepted.
- **Contention:** both requesters valid continuously with BURST_MAX = 4. Expect grants 0,0,0,0,1,1,1,1,0,… with no idle cycles after the first grant.
- **Swap during traffic:** `swap_req` pulses mid-stream and vsync rises 100 cycles later. Expect both readys low and `swap_busy` = 1 until the edge, `toggle`/`swap_done` for exactly 1 cycle one cycle after the edge, `frame_cnt` 0→1, and traffic resuming via IDLE.
- **Edge qualification:** `vsync` already high when `swap_req` arrives. Expect no `toggle` until `vsync` falls and rises again. A second `swap_req` while busy gives exactly one `toggle`.
- **Reset mid-swap:** `reset_n` = 0 in SWAP_WAIT. Expect all outputs 0 next cycle and no `toggle` on the subsequent vsync.
- **Wrap:** with `frame_cnt` preloaded via 65535 swaps (or forced), one more swap gives `frame_cnt` = 0.
